// File: rtl/seq_alu.sv
`default_nettype none
// ==========================================================================
// seq_alu : multi-cycle sign-magnitude ALU (add, sub, shift-add mul, restoring div)
// Revision: 1.0
// ==========================================================================
module seq_alu #(
   parameter int N = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   input  logic [1:0]     S,
   output logic           busy,
   output logic           done,
   output logic [2*N-2:0] R,
   output logic           SF,
   output logic           ZF,
   output logic           DZF
);

   localparam int M  = N - 1;
   localparam int W  = 2 * M;
   localparam int CW = (N > 2) ? $clog2(N) : 1;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_next;

   logic            r_a_sgn;
   logic            r_b_sgn;
   logic [1:0]      r_op;
   logic [W-1:0]    r_a;
   logic [M-1:0]    r_b;
   logic [W-1:0]    r_acc;
   logic [M:0]      r_rem;
   logic [M-1:0]    r_quo;
   logic [CW-1:0]   r_cnt;

   logic            w_last;
   logic            w_b_zero;
   logic            w_b_sgn_eff;
   logic [M:0]      w_am;
   logic [M:0]      w_bm;
   logic [M:0]      w_add_mag;
   logic            w_add_sgn;
   logic [W-1:0]    w_acc_next;
   logic [M:0]      w_trial;
   logic            w_ge;
   logic [M:0]      w_rem_next;
   logic [M-1:0]    w_quo_next;
   logic [W-1:0]    w_res_mag;
   logic            w_res_sgn;
   logic            w_res_zero;
   logic            w_dz;

   always_comb begin
      w_state_next = r_state;
      busy         = (r_state != IDLE);
      done         = (r_state == FIN);
      case (r_state)
         IDLE:    if (start) w_state_next = RUN;
         RUN:     if (w_last) w_state_next = FIN;
         FIN:     w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   assign w_b_zero = (r_b == '0);
   assign w_dz     = (r_op == OP_DIV) && w_b_zero;
   assign w_last   = (r_op == OP_ADD) || (r_op == OP_SUB) || w_dz ||
                     (r_cnt == CW'(M - 1));

   // Subtraction is addition with B's sign flipped; a zero result gets its sign cleared later
   always_comb begin
      w_b_sgn_eff = r_b_sgn ^ (r_op == OP_SUB);
      w_am        = {1'b0, r_a[M-1:0]};
      w_bm        = {1'b0, r_b};
      w_add_mag   = w_am + w_bm;
      w_add_sgn   = r_a_sgn;
      if (r_a_sgn != w_b_sgn_eff) begin
         if (w_am >= w_bm) begin
            w_add_mag = w_am - w_bm;
            w_add_sgn = r_a_sgn;
         end else begin
            w_add_mag = w_bm - w_am;
            w_add_sgn = w_b_sgn_eff;
         end
      end
   end

   assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);

   // Restoring step: dividend bits enter MSB-first from r_a[M-1] as r_a shifts left
   assign w_trial    = (r_rem << 1) | (M + 1)'(r_a[M-1]);
   assign w_ge       = (w_trial >= w_bm);
   assign w_rem_next = w_ge ? (w_trial - w_bm) : w_trial;
   assign w_quo_next = (r_quo << 1) | M'(w_ge);

   always_comb begin
      w_res_mag = W'(w_add_mag);
      w_res_sgn = w_add_sgn;
      case (r_op)
         OP_MUL: begin
            w_res_mag = w_acc_next;
            w_res_sgn = r_a_sgn ^ r_b_sgn;
         end
         OP_DIV: begin
            w_res_mag = w_b_zero ? '0 : W'(w_quo_next);
            w_res_sgn = r_a_sgn ^ r_b_sgn;
         end
         default: ;
      endcase
      w_res_zero = (w_res_mag == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_sgn <= 1'b0;
         r_b_sgn <= 1'b0;
         r_op    <= OP_ADD;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_cnt   <= '0;
         R       <= '0;
         SF      <= 1'b0;
         ZF      <= 1'b0;
         DZF     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a_sgn <= A[N-1];
                  r_b_sgn <= B[N-1];
                  r_op    <= S;
                  r_a     <= W'(A[M-1:0]);
                  r_b     <= B[M-1:0];
                  r_acc   <= '0;
                  r_rem   <= '0;
                  r_quo   <= '0;
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_cnt <= r_cnt + CW'(1);
               r_a   <= r_a << 1;
               if (r_op == OP_MUL) r_b <= r_b >> 1;
               r_acc <= w_acc_next;
               r_rem <= w_rem_next;
               r_quo <= w_quo_next;
               if (w_last) begin
                  R   <= {w_res_sgn & ~w_res_zero, w_res_mag};
                  SF  <= w_res_sgn & ~w_res_zero;
                  ZF  <= w_res_zero;
                  DZF <= w_dz;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
